// File: rtl/adc_serial_reader.sv
// ---------------------------------------------------------------------------
// adc_serial_reader
//
// Serial front-end for an SPI-style multi-channel ADC. Each conversion is one
// frame: CS_n drops, SCLK runs FRAME_BITS periods while the channel address
// is driven on DIN and the ADC result is shifted in from DOUT, then CS_n
// rises and the captured sample is offered on a valid/ready handshake tagged
// with its channel. Supports single-shot, continuous and channel-scan modes.
// An unread sample overwritten by a newer one raises a sticky overrun flag.
//
// Ports:
//   clk             system clock
//   rst             asynchronous, active-high reset
//   i_start         single-cycle conversion request (honoured in IDLE only)
//   i_cont          1 = start a new frame automatically after each frame
//   i_scan          1 = channel taken from the auto-incrementing scan pointer
//   i_ch_sel        channel for non-scan frames, latched at frame start
//   i_ad_dout       ADC serial data out
//   o_ad_cs_n       ADC chip select, active low
//   o_ad_sclk       ADC serial clock, idles high
//   o_ad_din        ADC command/address bit
//   o_sample_data   captured sample (last DATA_W bits of the frame)
//   o_sample_ch     channel the sample belongs to
//   o_sample_valid  sample available
//   i_sample_ready  consumer accepts the sample when valid && ready
//   o_busy          high whenever the FSM is not IDLE
//   o_overrun       sticky: an unread sample was overwritten
//   i_overrun_clr   clears o_overrun (a new overrun in the same cycle wins)
// ---------------------------------------------------------------------------
module adc_serial_reader #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CH     = 8,
  parameter int CH_W       = 3,
  parameter int CMD_POS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_scan,
  input  logic [CH_W-1:0]   i_ch_sel,
  input  logic              i_ad_dout,
  output logic              o_ad_cs_n,
  output logic              o_ad_sclk,
  output logic              o_ad_din,
  output logic [DATA_W-1:0] o_sample_data,
  output logic [CH_W-1:0]   o_sample_ch,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  output logic              o_busy,
  output logic              o_overrun,
  input  logic              i_overrun_clr
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [DIV_W-1:0]         r_divCnt;
  logic [BIT_W-1:0]         r_bitCnt;
  logic                     r_highPhase;
  logic [DATA_W-1:0]        r_shiftReg;
  logic [FRAME_BITS-1:0]    r_cmdShift;
  logic [CH_W-1:0]          r_chLatched;
  logic [CH_W-1:0]          r_scanPtr;
  logic                     r_csN;
  logic                     r_sclk;
  logic                     r_din;
  logic [DATA_W-1:0]        r_sampleData;
  logic [CH_W-1:0]          r_sampleCh;
  logic                     r_valid;
  logic                     r_overrun;

  logic                     w_divDone;
  logic [CH_W-1:0]          w_chNext;
  logic [FRAME_BITS+CH_W-1:0] w_cmdExt;
  logic [FRAME_BITS-1:0]    w_cmdWord;
  logic                     w_startFrame;
  logic                     w_fall;
  logic                     w_rise;
  logic                     w_enterHold;
  logic                     w_load;

  assign w_divDone = (r_divCnt == DIV_LAST);
  assign w_chNext  = i_scan ? r_scanPtr : i_ch_sel;

  // Command word in DIN order: bit FRAME_BITS-1 goes out first. The address
  // is placed MSB-first starting CMD_POS positions in; bits that would fall
  // past the end of the frame are dropped by the final truncation.
  assign w_cmdExt  = {{FRAME_BITS{1'b0}}, w_chNext} << (FRAME_BITS - CMD_POS);
  assign w_cmdWord = FRAME_BITS'(w_cmdExt >> CH_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and single-cycle strobes for the datapath. Every phase
  // lasts CLK_DIV cycles; w_divDone marks the last cycle of a phase. GAP
  // chains straight into SETUP in continuous mode so CS_n stays high for
  // exactly CLK_DIV cycles between back-to-back frames.
  always_comb begin
    w_stateNext  = r_state;
    w_startFrame = 1'b0;
    w_fall       = 1'b0;
    w_rise       = 1'b0;
    w_enterHold  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start || i_cont) begin
          w_stateNext  = SETUP;
          w_startFrame = 1'b1;
        end
      end
      SETUP: begin
        if (w_divDone) begin
          w_stateNext = SHIFT;
          w_fall      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_divDone) begin
          if (!r_highPhase) begin
            w_rise = 1'b1;
          end else if (r_bitCnt == BIT_LAST) begin
            w_stateNext = HOLD;
            w_enterHold = 1'b1;
          end else begin
            w_fall = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_divDone) begin
          w_stateNext = GAP;
          w_load      = 1'b1;
        end
      end
      GAP: begin
        if (w_divDone) begin
          if (i_cont) begin
            w_stateNext  = SETUP;
            w_startFrame = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Pin generation, phase timing and capture. The divider restarts at every
  // phase boundary. DIN changes only on SCLK falling edges, and DOUT is
  // sampled in the cycle SCLK is driven high. The command shifter advances
  // on each rising edge so the next falling edge picks up the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt    <= '0;
      r_bitCnt    <= '0;
      r_highPhase <= 1'b0;
      r_shiftReg  <= '0;
      r_cmdShift  <= '0;
      r_chLatched <= '0;
      r_scanPtr   <= '0;
      r_csN       <= 1'b1;
      r_sclk      <= 1'b1;
      r_din       <= 1'b0;
    end else begin
      r_divCnt <= (r_state == IDLE || w_divDone) ? '0 : r_divCnt + DIV_W'(1);
      if (w_startFrame) begin
        r_csN       <= 1'b0;
        r_sclk      <= 1'b1;
        r_din       <= w_cmdWord[FRAME_BITS-1];
        r_cmdShift  <= w_cmdWord;
        r_shiftReg  <= '0;
        r_bitCnt    <= '0;
        r_highPhase <= 1'b0;
        r_chLatched <= w_chNext;
      end
      if (w_fall) begin
        r_sclk      <= 1'b0;
        r_highPhase <= 1'b0;
        r_din       <= r_cmdShift[FRAME_BITS-1];
        if (r_state == SHIFT) begin
          r_bitCnt <= r_bitCnt + BIT_W'(1);
        end
      end
      if (w_rise) begin
        r_sclk      <= 1'b1;
        r_highPhase <= 1'b1;
        r_shiftReg  <= DATA_W'({r_shiftReg, i_ad_dout});
        r_cmdShift  <= r_cmdShift << 1;
      end
      if (w_enterHold && i_scan) begin
        r_scanPtr <= (r_scanPtr == CH_LAST) ? '0 : r_scanPtr + CH_W'(1);
      end
      if (w_load) begin
        r_csN <= 1'b1;
        r_din <= 1'b0;
      end
    end
  end

  // Output handshake. A load always wins over a transfer in the same cycle;
  // loading over a sample nobody has taken is what flags an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampleData <= '0;
      r_sampleCh   <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_sampleData <= r_shiftReg;
        r_sampleCh   <= r_chLatched;
        r_valid      <= 1'b1;
      end else if (r_valid && i_sample_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load && r_valid && !i_sample_ready) begin
        r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_ad_cs_n      = r_csN;
  assign o_ad_sclk      = r_sclk;
  assign o_ad_din       = r_din;
  assign o_sample_data  = r_sampleData;
  assign o_sample_ch    = r_sampleCh;
  assign o_sample_valid = r_valid;
  assign o_overrun      = r_overrun;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_adc_serial_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_reader
//
// Directed bench for adc_serial_reader. Instance dut uses the default build
// (16-bit frame, CLK_DIV=2); instance dutB is the CLK_DIV=1, 12-bit frame
// build. Each instance is driven by a small behavioural ADC that shifts out a
// preset word on SCLK falling edges and records DIN, CS_n timing and SCLK
// widths. Expected samples are queued when a conversion is requested and
// compared when the design presents them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_serial_reader;

  typedef struct packed {
    logic [11:0] data;
    logic [2:0]  ch;
  } sample_t;

  logic clk = 1'b0;
  logic rst;

  // Default build signals
  logic        start, cont, scan, adDout, sReady, ovClr;
  logic [2:0]  chSel;
  logic        csN, sclk, din, sValid, busy, overrun;
  logic [11:0] sData;
  logic [2:0]  sCh;

  // CLK_DIV=1 build signals
  logic        startB, contB, scanB, adDoutB, sReadyB, ovClrB;
  logic [2:0]  chSelB;
  logic        csNB, sclkB, dinB, sValidB, busyB, overrunB;
  logic [11:0] sDataB;
  logic [2:0]  sChB;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  sample_t expQ[$];

  always #5 clk = ~clk;

  adc_serial_reader dut (
    .clk(clk), .rst(rst),
    .i_start(start), .i_cont(cont), .i_scan(scan), .i_ch_sel(chSel),
    .i_ad_dout(adDout),
    .o_ad_cs_n(csN), .o_ad_sclk(sclk), .o_ad_din(din),
    .o_sample_data(sData), .o_sample_ch(sCh), .o_sample_valid(sValid),
    .i_sample_ready(sReady), .o_busy(busy), .o_overrun(overrun),
    .i_overrun_clr(ovClr)
  );

  adc_serial_reader #(
    .FRAME_BITS(12), .DATA_W(12), .CLK_DIV(1), .NUM_CH(8), .CH_W(3), .CMD_POS(2)
  ) dutB (
    .clk(clk), .rst(rst),
    .i_start(startB), .i_cont(contB), .i_scan(scanB), .i_ch_sel(chSelB),
    .i_ad_dout(adDoutB),
    .o_ad_cs_n(csNB), .o_ad_sclk(sclkB), .o_ad_din(dinB),
    .o_sample_data(sDataB), .o_sample_ch(sChB), .o_sample_valid(sValidB),
    .i_sample_ready(sReadyB), .o_busy(busyB), .o_overrun(overrunB),
    .i_overrun_clr(ovClrB)
  );

  // ADC model for the default build: latch the word at CS_n fall, present
  // one bit per SCLK falling edge MSB-first, record DIN on rising edges.
  logic [15:0] aWord = 16'h0;
  logic [15:0] aSh = 16'h0;
  logic [15:0] aDinCap = 16'h0;
  int  aFalls = 0, aFrames = 0, aLowLen = 0, aGapLen = 0;
  time aTFall = 0, aTRise = 0;

  always @(negedge csN) begin
    aSh     = aWord;
    aFalls  = 0;
    aDinCap = 16'h0;
    aGapLen = int'(($time - aTRise) / 10);
    aTFall  = $time;
  end

  always @(posedge csN) begin
    aLowLen = int'(($time - aTFall) / 10);
    aTRise  = $time;
    aFrames++;
  end

  always @(negedge sclk) begin
    if (csN == 1'b0) begin
      adDout = aSh[15];
      aSh    = aSh << 1;
      aFalls++;
    end
  end

  always @(posedge sclk) begin
    if (csN == 1'b0) aDinCap = {aDinCap[14:0], din};
  end

  // ADC model for the CLK_DIV=1 build, also tracking every SCLK half-period
  // inside the frame (each should be exactly one clk cycle).
  logic [11:0] bWord = 12'h0;
  logic [11:0] bSh = 12'h0;
  int  bLowLen = 0, bEdges = 0, bSclkBad = 0;
  time bTFall = 0, bTEdge = 0;

  always @(negedge csNB) begin
    bSh    = bWord;
    bTFall = $time;
    bTEdge = $time;
    bEdges = 0;
  end

  always @(posedge csNB) begin
    bLowLen = int'(($time - bTFall) / 10);
  end

  always @(negedge sclkB) begin
    if (csNB == 1'b0) begin
      adDoutB = bSh[11];
      bSh     = bSh << 1;
      if ($time - bTEdge != 10) bSclkBad++;
      bTEdge = $time;
      bEdges++;
    end
  end

  always @(posedge sclkB) begin
    if (csNB == 1'b0) begin
      if ($time - bTEdge != 10) bSclkBad++;
      bTEdge = $time;
      bEdges++;
    end
  end

  // Single comparison point: counts and reports through an immediate assert.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdleA(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic waitValidA(input string tag);
    int n = 0;
    while (!sValid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, sValid}, 32'd1);
  endtask

  // Wait for a sample, pop the oldest expectation and compare data/channel.
  task automatic popCheckA(input string tag);
    sample_t e;
    waitValidA(tag);
    checkOutput({tag, "_queued"}, {31'd0, expQ.size() != 0}, 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_data"}, {20'd0, sData}, {20'd0, e.data});
      checkOutput({tag, "_ch"}, {29'd0, sCh}, {29'd0, e.ch});
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int n;
    sample_t eB;

    rst = 1'b1;
    start = 1'b0; cont = 1'b0; scan = 1'b0; chSel = 3'd0; adDout = 1'b0;
    sReady = 1'b1; ovClr = 1'b0;
    startB = 1'b0; contB = 1'b0; scanB = 1'b0; chSelB = 3'd0; adDoutB = 1'b0;
    sReadyB = 1'b1; ovClrB = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_cs_n", {31'd0, csN}, 32'd1);
    checkOutput("rst_sclk", {31'd0, sclk}, 32'd1);
    checkOutput("rst_din", {31'd0, din}, 32'd0);
    checkOutput("rst_data", {20'd0, sData}, 32'd0);
    checkOutput("rst_ch", {29'd0, sCh}, 32'd0);
    checkOutput("rst_valid", {31'd0, sValid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle_cs", {31'd0, csN}, 32'd1);

    $display("[TB] single shot, channel 5");
    aWord = 16'h0ABC;
    chSel = 3'd5;
    expQ.push_back('{data: 12'hABC, ch: 3'd5});
    applyStimulus();
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    popCheckA("t1");
    checkOutput("t1_cs_low", aLowLen, 68);
    checkOutput("t1_din_addr", {29'd0, aDinCap[13:11]}, 32'b101);
    checkOutput("t1_din_other", {16'd0, aDinCap & 16'hC7FF}, 32'd0);
    @(negedge clk);
    checkOutput("t1_valid_one_cycle", {31'd0, sValid}, 32'd0);
    waitIdleA("t1_idle");

    $display("[TB] continuous scan, 10 frames");
    f0 = aFrames;
    aWord = 16'h0C5A;
    scan = 1'b1;
    for (int i = 0; i < 10; i++) expQ.push_back('{data: 12'hC5A, ch: 3'(i % 8)});
    cont = 1'b1;
    for (int i = 0; i < 10; i++) begin
      popCheckA($sformatf("t2_f%0d", i));
      if (i == 9) cont = 1'b0;
      @(negedge clk);
    end
    checkOutput("t2_gap", aGapLen, 2);
    checkOutput("t2_cs_low", aLowLen, 68);
    waitIdleA("t2_idle");
    repeat (150) @(negedge clk);
    checkOutput("t2_frames", aFrames - f0, 10);
    scan = 1'b0;

    $display("[TB] overrun with stalled consumer");
    sReady = 1'b0;
    chSel = 3'd1;
    aWord = 16'h0111;
    expQ.push_back('{data: 12'h111, ch: 3'd1});
    applyStimulus();
    waitValidA("t3_first");
    checkOutput("t3_no_overrun_yet", {31'd0, overrun}, 32'd0);
    waitIdleA("t3_idle1");
    aWord = 16'h0222;
    expQ.push_back('{data: 12'h222, ch: 3'd1});
    applyStimulus();
    waitIdleA("t3_idle2");
    checkOutput("t3_overrun_set", {31'd0, overrun}, 32'd1);
    checkOutput("t3_valid_held", {31'd0, sValid}, 32'd1);
    // The first sample was overwritten without being taken.
    void'(expQ.pop_front());
    sReady = 1'b1;
    popCheckA("t3");
    @(negedge clk);
    checkOutput("t3_valid_dropped", {31'd0, sValid}, 32'd0);
    checkOutput("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    ovClr = 1'b1;
    @(negedge clk);
    ovClr = 1'b0;
    checkOutput("t3_overrun_cleared", {31'd0, overrun}, 32'd0);

    $display("[TB] reset mid-frame");
    chSel = 3'd3;
    aWord = 16'h0777;
    applyStimulus();
    n = 0;
    while (aFalls < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_reached_sclk7", aFalls, 7);
    rst = 1'b1;
    #1;
    checkOutput("t4_cs_n", {31'd0, csN}, 32'd1);
    checkOutput("t4_sclk", {31'd0, sclk}, 32'd1);
    checkOutput("t4_valid", {31'd0, sValid}, 32'd0);
    checkOutput("t4_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    aWord = 16'h0456;
    chSel = 3'd6;
    expQ.push_back('{data: 12'h456, ch: 3'd6});
    applyStimulus();
    popCheckA("t4");
    checkOutput("t4_cs_low", aLowLen, 68);
    checkOutput("t4_din_addr", {29'd0, aDinCap[13:11]}, 32'b110);
    waitIdleA("t4_idle");

    $display("[TB] start while busy, start with cont");
    f0 = aFrames;
    aWord = 16'h0321;
    chSel = 3'd2;
    expQ.push_back('{data: 12'h321, ch: 3'd2});
    applyStimulus();
    repeat (20) @(negedge clk);
    applyStimulus();
    popCheckA("t5a");
    waitIdleA("t5a_idle");
    repeat (100) @(negedge clk);
    checkOutput("t5a_frames", aFrames - f0, 1);
    checkOutput("t5a_no_extra_valid", {31'd0, sValid}, 32'd0);

    f0 = aFrames;
    aWord = 16'h0654;
    chSel = 3'd7;
    expQ.push_back('{data: 12'h654, ch: 3'd7});
    cont = 1'b1;
    applyStimulus();
    popCheckA("t5b");
    cont = 1'b0;
    checkOutput("t5b_cs_low", aLowLen, 68);
    waitIdleA("t5b_idle");
    repeat (100) @(negedge clk);
    checkOutput("t5b_frames", aFrames - f0, 1);
    checkOutput("t5_queue_drained", expQ.size(), 0);

    $display("[TB] CLK_DIV=1, 12-bit frame build");
    bWord = 12'h9C3;
    chSelB = 3'd4;
    eB = '{data: 12'h9C3, ch: 3'd4};
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    n = 0;
    while (!sValidB && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_valid", {31'd0, sValidB}, 32'd1);
    checkOutput("t6_data", {20'd0, sDataB}, {20'd0, eB.data});
    checkOutput("t6_ch", {29'd0, sChB}, {29'd0, eB.ch});
    checkOutput("t6_cs_low", bLowLen, 26);
    checkOutput("t6_sclk_edges", bEdges, 24);
    checkOutput("t6_sclk_duty", bSclkBad, 0);
    @(negedge clk);
    checkOutput("t6_valid_one_cycle", {31'd0, sValidB}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
